// File: rtl/tpu_pkg.sv
// ---------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the operand feed path of the systolic array.
//   - default sizing for operand width, row count and vector-count width
//   - feeder FSM state encoding
//   - lane_lsb(): bit offset of lane `lane` inside a packed multi-lane bus
// ---------------------------------------------------------------------------
package tpu_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ROWS_DEF       = 4;
    localparam int LEN_W_DEF      = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_t;

    // Lane r of a packed bus lives at [r*width +: width].
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// ---------------------------------------------------------------------------
// skew_delay_line
// Parallel data+valid shift register, DEPTH stages deep. Stage 0 captures
// i_data only when i_valid is high and loads zero otherwise, so data is zero
// wherever valid is low all the way down the line.
//
// Ports:
//   clk        in   rising-edge clock
//   i_clear_n  in   asynchronous active-low clear of every stage
//   i_data     in   DATA_WIDTH  stage-0 data
//   i_valid    in   stage-0 valid
//   o_data     out  DATA_WIDTH  last-stage data
//   o_valid    out  last-stage valid
//   o_pending  out  a valid word sits in some stage other than the last
// ---------------------------------------------------------------------------
module skew_delay_line #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  i_clear_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_pending
);

    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_valid;

    always_ff @(posedge clk or negedge i_clear_n) begin
        if (!i_clear_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
            r_valid <= '0;
        end else begin
            r_data[0]  <= i_valid ? i_data : '0;
            r_valid[0] <= i_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_data[i]  <= r_data[i-1];
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    assign o_data  = r_data[DEPTH-1];
    assign o_valid = r_valid[DEPTH-1];

    // The last stage is what the array sees this cycle. If nothing valid
    // sits behind it, the line is empty after the next edge.
    always_comb begin
        o_pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            o_pending = o_pending | r_valid[i];
        end
    end

endmodule

// File: rtl/operand_skew_feeder.sv
// ---------------------------------------------------------------------------
// operand_skew_feeder
// Drains ROWS operand FIFOs in lockstep and presents lane r to the systolic
// array's west edge delayed by r extra cycles (diagonal skew). A read issued
// in cycle t appears on lane r in cycle t+2+r. Cycles where any FIFO is
// empty issue no read on any lane and travel down the skew as zero-data,
// valid-low bubbles.
//
// Optional build macro FEEDER_STALL_CNT_EN adds the stall_cycles output:
// number of STREAM cycles whose read was blocked by an empty lane,
// saturating at 0xFFFF, cleared on reset and on every accepted start.
//
// Ports:
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   start         in   one-cycle start pulse, honoured in IDLE only
//   len           in   LEN_W  column vectors to stream, sampled with start
//   busy          out  high in STREAM and DRAIN
//   done          out  one-cycle pulse at transfer end
//   fifo_rd_en    out  ROWS  per-lane FIFO read strobe (all equal)
//   fifo_data     in   ROWS*DATA_WIDTH  FIFO data, valid cycle after rd_en
//   fifo_empty    in   ROWS  per-lane FIFO empty flag
//   a_data        out  ROWS*DATA_WIDTH  skewed operands, same lane packing
//   a_valid       out  ROWS  per-lane operand valid
//   stall_cycles  out  16  (FEEDER_STALL_CNT_EN only) blocked-read count
// ---------------------------------------------------------------------------
module operand_skew_feeder
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ROWS       = ROWS_DEF,
    parameter int LEN_W      = LEN_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [LEN_W-1:0]           len,
    output logic                       busy,
    output logic                       done,
    output logic [ROWS-1:0]            fifo_rd_en,
    input  logic [ROWS*DATA_WIDTH-1:0] fifo_data,
    input  logic [ROWS-1:0]            fifo_empty,
    output logic [ROWS*DATA_WIDTH-1:0] a_data,
    output logic [ROWS-1:0]            a_valid
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]                stall_cycles
`endif
);

    feeder_state_t     r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_issued;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_issue_d;

    logic              w_any_empty;
    logic              w_can_read;
    logic              w_pipe_idle;
    logic [ROWS-1:0]   w_lane_pending;

    // The read decision looks at this cycle's empty flags directly: a
    // registered decision would act on a flag that may already be stale
    // by one read, which could pop an empty FIFO.
    assign w_any_empty = |fifo_empty;
    assign w_can_read  = (r_state == ST_STREAM) && !w_any_empty && (r_issued < r_len);
    assign fifo_rd_en  = {ROWS{w_can_read}};

    // Nothing in flight: no FIFO word arriving and no lane holding a valid
    // word behind its output stage.
    assign w_pipe_idle = !r_rd_issue_d && (w_lane_pending == '0);

    assign busy = r_busy;
    assign done = r_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_issue_d <= 1'b0;
        end else begin
            r_rd_issue_d <= w_can_read;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_len    <= '0;
            r_issued <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            r_len    <= len;
                            r_issued <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= ST_STREAM;
                        end else begin
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_can_read) begin
                        r_issued <= r_issued + 1'b1;
                    end
                    if (r_issued == r_len) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_pipe_idle) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Lane r: one capture stage plus r skew stages.
    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_lane
            skew_delay_line #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (gi + 1)
            ) u_delay (
                .clk       (clk),
                .i_clear_n (reset_n),
                .i_data    (fifo_data[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH]),
                .i_valid   (r_rd_issue_d),
                .o_data    (a_data[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH]),
                .o_valid   (a_valid[gi]),
                .o_pending (w_lane_pending[gi])
            );
        end
    endgenerate

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_stall_cycles <= '0;
        end else if ((r_state == ST_STREAM) && w_any_empty && (r_issued < r_len)
                     && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule
